// File: rtl/gpio_input_debouncer_if.sv
// ---------------------------------------------------------------------------
// gpio_input_debouncer_if
// Bundles the pin-side inputs and the conditioned outputs of the GPIO input
// debouncer so the peripheral side and the debouncer share one connection.
//   en         : debounce enable (driven by master)
//   pins_in    : raw asynchronous pin levels (driven by master)
//   pins_out   : debounced stable levels (driven by slave)
//   rise_pulse : one-cycle committed 0->1 pulse per channel (driven by slave)
//   fall_pulse : one-cycle committed 1->0 pulse per channel (driven by slave)
//   any_change : OR of all rise/fall pulses (driven by slave)
// ---------------------------------------------------------------------------
interface gpio_input_debouncer_if #(
  parameter int WIDTH = 12
);
  logic             en;
  logic [WIDTH-1:0] pins_in;
  logic [WIDTH-1:0] pins_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             any_change;

  modport master (
    output en,
    output pins_in,
    input  pins_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_change
  );

  modport slave (
    input  en,
    input  pins_in,
    output pins_out,
    output rise_pulse,
    output fall_pulse,
    output any_change
  );
endinterface

// File: rtl/gpio_input_debouncer.sv
// ---------------------------------------------------------------------------
// gpio_input_debouncer
// Conditions raw GPIO pins before the GPIO controller's input read port.
// Each channel has a 2-flop synchronizer, a consecutive-sample debounce
// counter, a registered stable level and one-cycle rise/fall event pulses.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-low; clears all state
//   bus : gpio_input_debouncer_if.slave
//         (en, pins_in in; pins_out, rise_pulse, fall_pulse, any_change out)
// All outputs are registered; there is no combinational path from pins_in.
// ---------------------------------------------------------------------------
module gpio_input_debouncer #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  gpio_input_debouncer_if.slave        bus
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q;
  logic [WIDTH-1:0]            s2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            pins_q;
  logic [WIDTH-1:0]            pins_d;
  logic [WIDTH-1:0]            rise_q;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_q;
  logic [WIDTH-1:0]            fall_d;
  logic                        any_q;
  logic                        any_d;

  // Per-channel debounce decision, evaluated on the synchronized level.
  always_comb begin
    cnt_d  = cnt_q;
    pins_d = pins_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.en) begin
        // Disabled: counting restarts from zero once re-enabled.
        cnt_d[i] = '0;
      end else if (s2_q[i] == pins_q[i]) begin
        // Any return to the stable level discards partial progress.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        pins_d[i] = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      pins_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      // Synchronizer runs regardless of en.
      s1_q   <= bus.pins_in;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      pins_q <= pins_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign bus.pins_out   = pins_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.any_change = any_q;

endmodule
